sl_sync_receiver: RTL and testbench



---
 rtl/sl_pkg.sv | 24 ++
 rtl/sl_line_filter.sv | 44 ++++
 rtl/sl_sync_receiver.sv | 255 +++++++++++++++++++++++++
 tb/tb_sl_sync_receiver.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sl_pkg.sv
// Shared types for the SL line receiver: decoded symbols, receive FSM
// states and the status flags held alongside each completed word.
package sl_pkg;

    typedef enum logic [1:0] {
        SYM_ZERO,
        SYM_ONE,
        SYM_STOP
    } sym_t;

    typedef enum logic [1:0] {
        IDLE,
        SYMBOL,
        GAP
    } rx_state_t;

    typedef struct packed {
        logic parity_valid;
        logic err_short;
        logic err_overflow;
        logic err_timeout;
    } word_flags_t;

endpackage

// File: rtl/sl_line_filter.sv
// One SL line: two-flop synchroniser followed by a stability filter.
// The filtered output only follows the synchronised line after FILTER_LEN
// consecutive samples disagree with it, so shorter pulses vanish. Everything
// resets to 1 (idle line) so no symbol is seen coming out of reset.
module sl_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line_async,
    output logic line_filt
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FILTER_LEN - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] stab_cnt;

    // Synchronise, then count down while the line disagrees with the filtered value
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1   <= 1'b1;
            sync_q2   <= 1'b1;
            line_filt <= 1'b1;
            stab_cnt  <= CNT_LOAD;
        end else begin
            sync_q1 <= line_async;
            sync_q2 <= sync_q1;
            if (sync_q2 != line_filt) begin
                if (stab_cnt == '0) begin
                    line_filt <= sync_q2;
                    stab_cnt  <= CNT_LOAD;
                end else begin
                    stab_cnt <= stab_cnt - 1'b1;
                end
            end else begin
                stab_cnt <= CNT_LOAD;
            end
        end
    end

endmodule

// File: rtl/sl_sync_receiver.sv
// SL two-wire receiver: filtered lines -> symbol decode -> word assembly
// with parity check -> one-deep holding register with valid/ack.
// Optional macro SL_RX_TIMEOUT_EN compiles in the in-word idle timeout.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no word in progress, lines at 11
// SYMBOL | lines away from 11, accumulating which lines went low
// GAP    | between symbols of a word, lines back at 11
module sl_sync_receiver
    import sl_pkg::*;
#(
    parameter int MAX_BITS       = 32,
    parameter int FILTER_LEN     = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sl0,
    input  logic                          sl1,
    output logic                          wordInProcess,
    output logic                          wordValid,
    input  logic                          wordAck,
    output logic [MAX_BITS-1:0]           dataOut,
    output logic [$clog2(MAX_BITS+1)-1:0] bitCount,
    output logic                          parityValid,
    output logic                          errShort,
    output logic                          errOverflow,
    output logic                          errTimeout,
    output logic                          errOverrun
);

    localparam int BCW  = $clog2(MAX_BITS + 1);
    localparam int NSYM = MAX_BITS + 1;           // data bits plus parity
    localparam int SCW  = $clog2(MAX_BITS + 3);   // room for the overflow marker NSYM+1

    logic f0;
    logic f1;
    logic line_idle;

    rx_state_t state_q;
    rx_state_t state_d;

    logic            acc0_q;
    logic            acc1_q;
    sym_t            sym_d;
    logic [MAX_BITS-1:0] sym_sr_q;
    logic [SCW-1:0]  sym_cnt_q;
    logic            ones_odd_q;
    logic            zeros_odd_q;

    logic sym_start;
    logic sym_commit;
    logic word_done;
    logic word_tmo;
    logic tmo_hit;

    logic [SCW-1:0]      nbits;
    logic [MAX_BITS-1:0] word_data;
    logic                word_ovf;
    logic                word_short;
    word_flags_t         word_flags;
    word_flags_t         flags_q;

    sl_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt0 (
        .clk        (clk),
        .rst        (rst),
        .line_async (sl0),
        .line_filt  (f0)
    );

    sl_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt1 (
        .clk        (clk),
        .rst        (rst),
        .line_async (sl1),
        .line_filt  (f1)
    );

    assign line_idle     = f0 & f1;
    assign wordInProcess = (state_q != IDLE);

    // Both lines seen low at any point is a stop, even if they moved with skew
    assign sym_d = (acc0_q && acc1_q) ? SYM_STOP : (acc1_q ? SYM_ONE : SYM_ZERO);

`ifdef SL_RX_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCW-1:0] TMO_LOAD = TCW'(TIMEOUT_CYCLES - 1);

    logic [TCW-1:0] tmo_cnt_q;
    logic [1:0]     f_prev_q;

    // Count down idle clocks inside a word; any filtered line change reloads
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= TMO_LOAD;
            f_prev_q  <= 2'b11;
        end else begin
            f_prev_q <= {f1, f0};
            if (state_q == IDLE || {f1, f0} != f_prev_q) begin
                tmo_cnt_q <= TMO_LOAD;
            end else if (tmo_cnt_q != '0) begin
                tmo_cnt_q <= tmo_cnt_q - 1'b1;
            end
        end
    end

    assign tmo_hit = (state_q != IDLE) && ({f1, f0} == f_prev_q) && (tmo_cnt_q == '0);
`else
    // Timeout compiled out: a word waits indefinitely for its stop.
    assign tmo_hit = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle control strobes
    always_comb begin
        state_d    = state_q;
        sym_start  = 1'b0;
        sym_commit = 1'b0;
        word_done  = 1'b0;
        word_tmo   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!line_idle) begin
                    state_d   = SYMBOL;
                    sym_start = 1'b1;
                end
            end
            SYMBOL: begin
                if (line_idle) begin
                    if (sym_d == SYM_STOP) begin
                        state_d   = IDLE;
                        word_done = 1'b1;
                    end else begin
                        state_d    = GAP;
                        sym_commit = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_d   = IDLE;
                    word_done = 1'b1;
                    word_tmo  = 1'b1;
                end
            end
            GAP: begin
                if (!line_idle) begin
                    state_d   = SYMBOL;
                    sym_start = 1'b1;
                end else if (tmo_hit) begin
                    state_d   = IDLE;
                    word_done = 1'b1;
                    word_tmo  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Record which lines went low during the current symbol
    always_ff @(posedge clk) begin
        if (rst) begin
            acc0_q <= 1'b0;
            acc1_q <= 1'b0;
        end else if (sym_start) begin
            acc0_q <= ~f0;
            acc1_q <= ~f1;
        end else if (state_q == SYMBOL) begin
            acc0_q <= acc0_q | ~f0;
            acc1_q <= acc1_q | ~f1;
        end
    end

    // Assemble symbols: store, count and track parity of 1s and 0s
    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE) begin
            sym_sr_q    <= '0;
            sym_cnt_q   <= '0;
            ones_odd_q  <= 1'b0;
            zeros_odd_q <= 1'b0;
        end else if (sym_commit) begin
            if (sym_cnt_q < SCW'(NSYM)) begin
                for (int i = 0; i < MAX_BITS; i++) begin
                    if (sym_cnt_q == SCW'(i)) begin
                        sym_sr_q[i] <= (sym_d == SYM_ONE);
                    end
                end
                if (sym_d == SYM_ONE) begin
                    ones_odd_q <= ~ones_odd_q;
                end else begin
                    zeros_odd_q <= ~zeros_odd_q;
                end
                sym_cnt_q <= sym_cnt_q + 1'b1;
            end else begin
                // Saturate one past the limit to remember that symbols were dropped
                sym_cnt_q <= SCW'(NSYM + 1);
            end
        end
    end

    // Build the completed word: the last kept symbol is parity, not data
    always_comb begin
        word_ovf   = (sym_cnt_q > SCW'(NSYM));
        word_short = (sym_cnt_q < SCW'(2));
        nbits      = '0;
        if (word_ovf) begin
            nbits = SCW'(MAX_BITS);
        end else if (sym_cnt_q != '0) begin
            nbits = sym_cnt_q - 1'b1;
        end
        word_data = '0;
        for (int i = 0; i < MAX_BITS; i++) begin
            word_data[i] = sym_sr_q[i] && (SCW'(i) < nbits);
        end
        word_flags              = '0;
        word_flags.err_timeout  = word_tmo;
        word_flags.err_short    = word_short && !word_tmo;
        word_flags.err_overflow = word_ovf;
        word_flags.parity_valid = !word_tmo && !word_ovf && !word_short &&
                                  ones_odd_q && !zeros_odd_q;
    end

    // One-deep holding register with valid/ack and sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            wordValid  <= 1'b0;
            dataOut    <= '0;
            bitCount   <= '0;
            flags_q    <= '0;
            errOverrun <= 1'b0;
        end else if (word_done) begin
            if (!wordValid || wordAck) begin
                wordValid <= 1'b1;
                dataOut   <= word_data;
                bitCount  <= BCW'(nbits);
                flags_q   <= word_flags;
            end else begin
                errOverrun <= 1'b1;
            end
        end else if (wordAck && wordValid) begin
            wordValid <= 1'b0;
        end
    end

    assign parityValid = flags_q.parity_valid;
    assign errShort    = flags_q.err_short;
    assign errOverflow = flags_q.err_overflow;
    assign errTimeout  = flags_q.err_timeout;

endmodule

// File: tb/tb_sl_sync_receiver.sv
// Directed bench for sl_sync_receiver: words with hand-computed data, count
// and flags, skewed stop, glitches, overrun, same-cycle ack and reset.
module tb_sl_sync_receiver;

    localparam int MAX_BITS       = 32;
    localparam int FILTER_LEN     = 3;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int BCW            = $clog2(MAX_BITS + 1);
    localparam int HOLD           = 6;
    localparam int GAP            = 6;

    logic                clk = 1'b0;
    logic                rst;
    logic                sl0;
    logic                sl1;
    logic                wordAck;
    logic                wordInProcess;
    logic                wordValid;
    logic [MAX_BITS-1:0] dataOut;
    logic [BCW-1:0]      bitCount;
    logic                parityValid;
    logic                errShort;
    logic                errOverflow;
    logic                errTimeout;
    logic                errOverrun;

    int n_chk = 0;
    int n_bad = 0;

    sl_sync_receiver #(
        .MAX_BITS       (MAX_BITS),
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sl0           (sl0),
        .sl1           (sl1),
        .wordInProcess (wordInProcess),
        .wordValid     (wordValid),
        .wordAck       (wordAck),
        .dataOut       (dataOut),
        .bitCount      (bitCount),
        .parityValid   (parityValid),
        .errShort      (errShort),
        .errOverflow   (errOverflow),
        .errTimeout    (errTimeout),
        .errOverrun    (errOverrun)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // flags packed as {parityValid, errShort, errOverflow, errTimeout}
    task automatic check_word(input string tag, input logic [63:0] data, input int cnt,
                              input logic [3:0] flags);
        check_val({tag, "_data"}, dataOut, data);
        check_val({tag, "_cnt"}, bitCount, cnt);
        check_val({tag, "_flags"}, {parityValid, errShort, errOverflow, errTimeout}, flags);
    endtask

    task automatic send_sym(input logic v, input logic glitch);
        if (v) sl1 = 1'b0;
        else   sl0 = 1'b0;
        repeat (HOLD) @(negedge clk);
        sl0 = 1'b1;
        sl1 = 1'b1;
        if (glitch) begin
            repeat (8) @(negedge clk);
            sl0 = 1'b0;
            @(negedge clk);
            sl0 = 1'b1;
            repeat (8) @(negedge clk);
        end else begin
            repeat (GAP) @(negedge clk);
        end
    endtask

    task automatic send_bits(input logic [63:0] v, input int n, input logic glitch);
        for (int i = 0; i < n; i++) send_sym(v[i], glitch);
    endtask

    // Returns on the negedge where both pins go back high
    task automatic send_stop(input logic skew);
        sl0 = 1'b0;
        if (skew) @(negedge clk);
        sl1 = 1'b0;
        repeat (HOLD) @(negedge clk);
        sl0 = 1'b1;
        if (skew) @(negedge clk);
        sl1 = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!wordValid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_val({tag, "_valid"}, wordValid, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (wordInProcess && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_val({tag, "_idle"}, wordInProcess, 1'b0);
    endtask

    task automatic do_ack(input string tag);
        wordAck = 1'b1;
        @(negedge clk);
        wordAck = 1'b0;
        check_val({tag, "_acked"}, wordValid, 1'b0);
    endtask

    initial begin
        rst     = 1'b1;
        sl0     = 1'b1;
        sl1     = 1'b1;
        wordAck = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check_val("rst_valid", wordValid, 1'b0);
        check_val("rst_inproc", wordInProcess, 1'b0);
        check_val("rst_overrun", errOverrun, 1'b0);
        check_word("rst", 64'h0, 0, 4'b0000);

        // 1,0,1 + parity 1: ones=3 odd, zeros=1 odd -> parity fails
        send_sym(1'b1, 1'b0);
        check_val("w1_inproc", wordInProcess, 1'b1);
        send_bits(64'hD >> 1, 3, 1'b0);
        send_stop(1'b0);
        wait_valid("w1");
        check_word("w1", 64'h5, 3, 4'b0000);
        do_ack("w1");

        // 1,1,0,0 + parity 1: ones=3, zeros=2 -> parity ok
        send_bits(64'h13, 5, 1'b0);
        send_stop(1'b0);
        wait_valid("w2");
        check_word("w2", 64'h3, 4, 4'b1000);
        do_ack("w2");

        // 32 data bits of A5A5A5A5 (16 ones) + parity 1
        send_bits({31'h0, 1'b1, 32'hA5A5A5A5}, 33, 1'b0);
        send_stop(1'b0);
        wait_valid("w32");
        check_word("w32", 64'hA5A5A5A5, 32, 4'b1000);
        do_ack("w32");

        // 34 symbols: one beyond data+parity is dropped
        send_bits({30'h0, 2'b11, 32'hA5A5A5A5}, 34, 1'b0);
        send_stop(1'b0);
        wait_valid("ovf");
        check_word("ovf", 64'hA5A5A5A5, 32, 4'b0010);
        do_ack("ovf");

        // Glitches on sl0 in every gap and a skewed stop: decode unchanged
        send_bits(64'h13, 5, 1'b1);
        send_stop(1'b1);
        wait_valid("skew");
        check_word("skew", 64'h3, 4, 4'b1000);
        do_ack("skew");

        // Stop alone, then a single symbol before stop
        send_stop(1'b0);
        wait_valid("short0");
        check_word("short0", 64'h0, 0, 4'b0100);
        do_ack("short0");
        send_sym(1'b1, 1'b0);
        send_stop(1'b0);
        wait_valid("short1");
        check_word("short1", 64'h0, 0, 4'b0100);
        do_ack("short1");

        // Overrun: 0,1 + parity 0 held, second word (1,1,1 + 0) lost
        send_bits(64'h2, 3, 1'b0);
        send_stop(1'b0);
        wait_valid("ovr_a");
        check_word("ovr_a", 64'h2, 2, 4'b1000);
        send_bits(64'h7, 4, 1'b0);
        send_stop(1'b0);
        wait_idle("ovr_b");
        @(negedge clk);
        check_val("ovr_flag", errOverrun, 1'b1);
        check_word("ovr_kept", 64'h2, 2, 4'b1000);
        do_ack("ovr");

        // Reset mid-word discards it and clears the sticky overrun
        send_sym(1'b1, 1'b0);
        send_sym(1'b0, 1'b0);
        check_val("mid_inproc", wordInProcess, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_inproc0", wordInProcess, 1'b0);
        check_val("mid_valid0", wordValid, 1'b0);
        check_val("mid_overrun0", errOverrun, 1'b0);
        check_word("mid", 64'h0, 0, 4'b0000);
        repeat (4) @(negedge clk);
        // 0,1,1,0 + parity 1: ones=3, zeros=2
        send_bits(64'h16, 5, 1'b0);
        send_stop(1'b0);
        wait_valid("post");
        check_word("post", 64'h6, 4, 4'b1000);

        // Held word + new completion with ack on the completion edge.
        // Filtered lines reach 11 FILTER_LEN+2 clocks after release, the
        // word completes one clock later.
        send_bits(64'h19, 5, 1'b0);
        send_stop(1'b0);
        repeat (FILTER_LEN + 2) @(negedge clk);
        check_val("same_pre_data", dataOut, 64'h6);
        check_val("same_pre_inproc", wordInProcess, 1'b1);
        wordAck = 1'b1;
        @(negedge clk);
        wordAck = 1'b0;
        check_val("same_valid", wordValid, 1'b1);
        check_val("same_overrun", errOverrun, 1'b0);
        check_word("same", 64'h9, 4, 4'b1000);
        do_ack("same");

`ifdef SL_RX_TIMEOUT_EN
        // 1,0,1 then silence: aborted with the first two bits
        send_bits(64'h5, 3, 1'b0);
        repeat (20) @(negedge clk);
        check_val("tmo_inproc", wordInProcess, 1'b0);
        check_val("tmo_valid", wordValid, 1'b1);
        check_word("tmo", 64'h1, 2, 4'b0001);
        do_ack("tmo");
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
